owt_run_encoder: RTL and testbench

Transmit-side run-length encoder for the one-wire (OWT) link. It accepts a parallel data word over a valid/ready handshake. It serialises the word MSB-first, with an optional even-parity bit, as runs of RUN_LEN identical line samples on an o_vld/o_vld_data sample stream. That stream feeds the line driver, and the receive-side OWT-mode run detector decodes one bit per run.

---
 rtl/owt_run_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_owt_run_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/owt_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : owt_run_encoder
// Description : OWT transmit run-length encoder; serialises a data word
//               MSB-first (plus optional even parity) as RUN_LEN-sample runs.
// Revision    : 1.0 - initial release
// ============================================================================
module owt_run_encoder #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 10,
    parameter int RUN_LEN = 5,
    parameter int SMP_DIV = 1,
    parameter int PAR_EN  = 1,
    parameter int GAP_LEN = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_vld,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_rdy,
    input  logic              i_abort,
    output logic              o_vld,
    output logic              o_vld_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(SMP_DIV - 1);
    localparam logic [CNT_W-1:0] c_run_last = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            r_state,   w_nxt_state;
    logic [CNT_W-1:0]  r_div_cnt, w_nxt_div;
    logic [CNT_W-1:0]  r_run_cnt, w_nxt_run;
    logic [BIT_W-1:0]  r_bit_idx, w_nxt_bit;
    logic [DATA_W-1:0] r_shift,   w_nxt_shift;
    logic              r_par,     w_nxt_par;

    logic w_hs;
    logic w_slot_end, w_run_end, w_bit_end, w_gap_end;
    logic w_nxt_slot_end, w_nxt_run_end, w_nxt_bit_end, w_nxt_gap_end;
    logic w_nxt_last;
    logic w_nxt_vld;
    logic w_nxt_lvl;

    generate
        if (RUN_LEN < 1 || RUN_LEN >= 2**CNT_W) begin : g_chk_run_len
            $error("RUN_LEN out of range");
        end
        if (SMP_DIV < 1 || SMP_DIV >= 2**CNT_W) begin : g_chk_smp_div
            $error("SMP_DIV out of range");
        end
    endgenerate

    assign o_tx_rdy = (r_state == ST_IDLE) & ~i_abort;
    assign w_hs     = i_tx_vld & o_tx_rdy;

    assign w_slot_end = (r_div_cnt == c_div_last);
    assign w_run_end  = (r_run_cnt == c_run_last);
    assign w_bit_end  = (r_bit_idx == c_bit_last);
    assign w_gap_end  = (r_run_cnt == c_gap_last);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_div   = r_div_cnt;
        w_nxt_run   = r_run_cnt;
        w_nxt_bit   = r_bit_idx;
        w_nxt_shift = r_shift;
        w_nxt_par   = r_par;

        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_nxt_state = ST_DATA;
                    w_nxt_shift = i_tx_data;
                    w_nxt_par   = ^i_tx_data;
                    w_nxt_div   = '0;
                    w_nxt_run   = '0;
                    w_nxt_bit   = '0;
                end
            end
            ST_DATA: begin
                if (!w_slot_end) begin
                    w_nxt_div = r_div_cnt + CNT_W'(1);
                end else begin
                    w_nxt_div = '0;
                    if (!w_run_end) begin
                        w_nxt_run = r_run_cnt + CNT_W'(1);
                    end else begin
                        w_nxt_run = '0;
                        if (!w_bit_end) begin
                            w_nxt_bit   = r_bit_idx + BIT_W'(1);
                            w_nxt_shift = r_shift << 1;
                        end else begin
                            w_nxt_bit = '0;
                            if (PAR_EN != 0)
                                w_nxt_state = ST_PAR;
                            else if (GAP_LEN > 0)
                                w_nxt_state = ST_GAP;
                            else
                                w_nxt_state = ST_IDLE;
                        end
                    end
                end
            end
            ST_PAR: begin
                if (!w_slot_end) begin
                    w_nxt_div = r_div_cnt + CNT_W'(1);
                end else begin
                    w_nxt_div = '0;
                    if (!w_run_end) begin
                        w_nxt_run = r_run_cnt + CNT_W'(1);
                    end else begin
                        w_nxt_run = '0;
                        if (GAP_LEN > 0)
                            w_nxt_state = ST_GAP;
                        else
                            w_nxt_state = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (!w_slot_end) begin
                    w_nxt_div = r_div_cnt + CNT_W'(1);
                end else begin
                    w_nxt_div = '0;
                    if (w_gap_end) begin
                        w_nxt_run   = '0;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_run = r_run_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        // Abort discards the frame entirely; the next cycle looks like reset.
        if (i_abort && (r_state != ST_IDLE)) begin
            w_nxt_state = ST_IDLE;
            w_nxt_div   = '0;
            w_nxt_run   = '0;
            w_nxt_bit   = '0;
            w_nxt_shift = '0;
            w_nxt_par   = 1'b0;
        end
    end

    // Outputs are registered from the next-cycle view so they line up with
    // the state/counter values of the cycle in which they are visible.
    always_comb begin
        w_nxt_slot_end = (w_nxt_div == c_div_last);
        w_nxt_run_end  = (w_nxt_run == c_run_last);
        w_nxt_bit_end  = (w_nxt_bit == c_bit_last);
        w_nxt_gap_end  = (w_nxt_run == c_gap_last);
        w_nxt_last     = 1'b0;
        w_nxt_vld      = 1'b0;
        w_nxt_lvl      = 1'b0;
        case (w_nxt_state)
            ST_DATA: begin
                w_nxt_vld  = (w_nxt_div == '0);
                w_nxt_lvl  = w_nxt_shift[DATA_W-1];
                w_nxt_last = (PAR_EN == 0) && (GAP_LEN == 0) &&
                             w_nxt_slot_end && w_nxt_run_end && w_nxt_bit_end;
            end
            ST_PAR: begin
                w_nxt_vld  = (w_nxt_div == '0);
                w_nxt_lvl  = w_nxt_par;
                w_nxt_last = (GAP_LEN == 0) && w_nxt_slot_end && w_nxt_run_end;
            end
            ST_GAP: begin
                w_nxt_last = w_nxt_slot_end && w_nxt_gap_end;
            end
            default: begin
                w_nxt_last = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_run_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            o_vld      <= 1'b0;
            o_vld_data <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_div_cnt  <= w_nxt_div;
            r_run_cnt  <= w_nxt_run;
            r_bit_idx  <= w_nxt_bit;
            r_shift    <= w_nxt_shift;
            r_par      <= w_nxt_par;
            o_vld      <= w_nxt_vld;
            o_vld_data <= w_nxt_vld & w_nxt_lvl;
            o_busy     <= (w_nxt_state != ST_IDLE);
            o_done     <= w_nxt_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_owt_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_owt_run_encoder
// Description : Self-checking bench for owt_run_encoder; two parameter sets
//               checked cycle by cycle against a frame-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_owt_run_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_vld = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       abort = 1'b0;

    logic rdy0, vld0, dat0, busy0, done0;
    logic rdy1, vld1, dat1, busy1, done1;

    always #5 clk = ~clk;

    owt_run_encoder #(
        .DATA_W(8), .CNT_W(10), .RUN_LEN(5), .SMP_DIV(1), .PAR_EN(1), .GAP_LEN(2)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_vld(tx_vld), .i_tx_data(tx_data),
        .o_tx_rdy(rdy0), .i_abort(abort), .o_vld(vld0), .o_vld_data(dat0),
        .o_busy(busy0), .o_done(done0)
    );

    owt_run_encoder #(
        .DATA_W(8), .CNT_W(10), .RUN_LEN(5), .SMP_DIV(3), .PAR_EN(0), .GAP_LEN(2)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_vld(tx_vld), .i_tx_data(tx_data),
        .o_tx_rdy(rdy1), .i_abort(abort), .o_vld(vld1), .o_vld_data(dat1),
        .o_busy(busy1), .o_done(done1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic       act [2];
    int         t0  [2];
    logic [7:0] fd  [2];
    int         hs_prev [2];
    int         hs_cur  [2];
    logic       lb_q [$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int par_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int frame_len(input int i);
        return ((8 + par_of(i)) * 5 + 2) * div_of(i);
    endfunction

    // Expected {vld, data, busy, done} at a given cycle offset after the handshake.
    function automatic logic [3:0] exp_out(input int off, input logic [7:0] d,
                                           input int pen, input int div);
        int   n, f, s, k, b;
        logic v, dt, bz, dn;
        n = 8 + pen;
        f = (n * 5 + 2) * div;
        v = 1'b0; dt = 1'b0; bz = 1'b0; dn = 1'b0;
        if (off >= 1 && off <= f) begin
            bz = 1'b1;
            dn = (off == f);
            s  = off - 1;
            if ((s % div) == 0 && (s / div) < n * 5) begin
                k  = s / div;
                b  = k / 5;
                v  = 1'b1;
                dt = (b < 8) ? d[7-b] : ^d;
            end
        end
        return {v, dt, bz, dn};
    endfunction

    // Stand-in for the receive-side run detector: one bit per 5-sample run.
    task automatic check_loopback();
        logic [8:0] dec;
        logic       ok;
        dec = '0;
        ok  = (lb_q.size() == 45);
        if (ok) begin
            for (int j = 0; j < 9; j++) begin
                dec[8-j] = lb_q[j*5];
                for (int r = 1; r < 5; r++)
                    if (lb_q[j*5+r] !== lb_q[j*5]) ok = 1'b0;
            end
        end
        chk_val("loopback", {ok, dec}, {1'b1, fd[0], ^fd[0]});
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ab);
        logic [3:0] obs [2];
        logic [3:0] e;
        logic       rdy_o [2];
        logic       rdy_e;
        int         off;
        @(negedge clk);
        cyc++;
        obs[0] = {vld0, dat0, busy0, done0};
        obs[1] = {vld1, dat1, busy1, done1};
        for (int i = 0; i < 2; i++) begin
            off = cyc - t0[i];
            if (act[i] && off > frame_len(i)) act[i] = 1'b0;
            e = act[i] ? exp_out(off, fd[i], par_of(i), div_of(i)) : 4'b0000;
            chk_val((i == 0) ? "outs0" : "outs1", obs[i], e);
            if (i == 0) begin
                if (act[0] && vld0) lb_q.push_back(dat0);
                if (e[0]) check_loopback();
            end
        end
        tx_vld  = v;
        tx_data = d;
        abort   = ab;
        #1;
        rdy_o[0] = rdy0;
        rdy_o[1] = rdy1;
        for (int i = 0; i < 2; i++) begin
            rdy_e = !act[i] && !ab;
            chk_val((i == 0) ? "rdy0" : "rdy1", rdy_o[i], rdy_e);
            if (rdy_e && v) begin
                act[i]     = 1'b1;
                t0[i]      = cyc;
                fd[i]      = d;
                hs_prev[i] = hs_cur[i];
                hs_cur[i]  = cyc;
                if (i == 0) lb_q.delete();
            end else if (act[i] && ab) begin
                act[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk_val(tag, {vld0, dat0, busy0, done0, vld1, dat1, busy1, done1}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; t0[i] = 0; fd[i] = 8'h00; hs_prev[i] = -1; hs_cur[i] = -1;
        end

        repeat (2) @(negedge clk);
        check_zero("reset_outs");
        rst_n = 1'b1;

        // Single 0xA5 frame on both parameter sets
        step(1'b1, 8'hA5, 1'b0);
        idle(130);

        // Back-to-back with i_tx_vld held high: 0xFF then 0x00
        for (int k = 0; k < 48; k++) step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk_val("b2b_gap0", hs_cur[0] - hs_prev[0], 48);
        chk_val("b2b_data0", fd[0], 8'h00);
        step(1'b0, 8'h00, 1'b0);
        idle(130);

        // Abort at T+10 then a clean 0x3C loopback frame
        step(1'b1, 8'h5A, 1'b0);
        idle(9);
        step(1'b0, 8'h00, 1'b1);
        idle(3);
        step(1'b1, 8'h3C, 1'b0);
        idle(130);

        // Asynchronous reset mid-frame at T+20
        step(1'b1, 8'hC3, 1'b0);
        idle(19);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        act[0] = 1'b0;
        act[1] = 1'b0;
        step(1'b1, 8'h96, 1'b0);
        idle(130);

        // Randomised traffic with occasional aborts
        for (int k = 0; k < 4000; k++)
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 40) == 0);
        idle(130);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
